// File: rtl/ldpc_encoder_sched.sv
// rtl/ldpc_encoder_sched.sv - DVB-S2 LDPC encoder frame sequencer (clear, word fetch, 45-beat walk, drain)
// Optional macro LDPC_SCHED_PREFETCH_EN: fetch the next word during beats 42-43 so beats run back to back.
module ldpc_encoder_sched #(
  parameter int AW      = 8,
  parameter int ACC_LAT = 2
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          fs_en,
  input  logic          frame_start,
  input  logic [AW-1:0] num_words,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_addr,
  input  logic [359:0]  ram_rdata,
  input  logic [2:0]    ram_order,
  output logic          switch_vld,
  output logic [359:0]  ram_data,
  output logic [5:0]    switch_array,
  output logic [2:0]    order_array,
  output logic          reg_clr_vld,
  output logic          busy,
  output logic          frame_done
);

  localparam int DW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

  typedef enum logic [2:0] {IDLE, CLR, RD, LAT, BEAT, DRAIN} state_t;

  state_t         state_q, state_nx;
  logic [AW-1:0]  w_q, w_nx;
  logic [AW-1:0]  nw_q, nw_nx;
  logic [5:0]     b_q, b_nx;
  logic [DW-1:0]  d_q, d_nx;
  logic [359:0]   data_q, data_nx;
  logic [2:0]     ord_q, ord_nx;
  logic           done_q, done_nx;
  logic           go_drain;
  logic           last_word;
`ifdef LDPC_SCHED_PREFETCH_EN
  logic [359:0]   shd_data_q, shd_data_nx;
  logic [2:0]     shd_ord_q, shd_ord_nx;
`endif

  assign last_word    = (w_q == nw_q - AW'(1));
  assign busy         = (state_q != IDLE);
  assign frame_done   = done_q;
  assign ram_data     = data_q;
  assign switch_array = b_q;
  assign order_array  = ord_q;

  always_comb begin
    state_nx    = state_q;
    w_nx        = w_q;
    nw_nx       = nw_q;
    b_nx        = b_q;
    d_nx        = d_q;
    data_nx     = data_q;
    ord_nx      = ord_q;
    done_nx     = 1'b0;
    go_drain    = 1'b0;
    ram_rd_en   = 1'b0;
    ram_addr    = '0;
    switch_vld  = 1'b0;
    reg_clr_vld = 1'b0;
`ifdef LDPC_SCHED_PREFETCH_EN
    shd_data_nx = shd_data_q;
    shd_ord_nx  = shd_ord_q;
`endif
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          nw_nx = num_words;
          if (num_words == '0) go_drain = 1'b1;
          else                 state_nx = CLR;
        end
      end
      CLR: begin
        reg_clr_vld = 1'b1;
        w_nx        = '0;
        state_nx    = RD;
      end
      RD: begin
        ram_rd_en = 1'b1;
        ram_addr  = w_q;
        state_nx  = LAT;
      end
      LAT: begin
        data_nx  = ram_rdata;
        ord_nx   = ram_order;
        b_nx     = '0;
        state_nx = BEAT;
      end
      BEAT: begin
        switch_vld = 1'b1;
`ifdef LDPC_SCHED_PREFETCH_EN
        if (!last_word && b_q == 6'd42) begin
          ram_rd_en = 1'b1;
          ram_addr  = w_q + AW'(1);
        end
        if (!last_word && b_q == 6'd43) begin
          shd_data_nx = ram_rdata;
          shd_ord_nx  = ram_order;
        end
`endif
        if (b_q == 6'd44) begin
          b_nx = '0;
          if (last_word) begin
            go_drain = 1'b1;
          end else begin
            w_nx = w_q + AW'(1);
`ifdef LDPC_SCHED_PREFETCH_EN
            data_nx = shd_data_q;
            ord_nx  = shd_ord_q;
`else
            state_nx = RD;
`endif
          end
        end else begin
          b_nx = b_q + 6'd1;
        end
      end
      DRAIN: begin
        if (d_q == DW'(ACC_LAT - 1)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          d_nx     = '0;
        end else begin
          d_nx = d_q + DW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // A zero-latency pipeline skips DRAIN and completes on the next edge.
    if (go_drain) begin
      d_nx = '0;
      if (ACC_LAT == 0) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end else begin
        state_nx = DRAIN;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      w_q        <= '0;
      nw_q       <= '0;
      b_q        <= '0;
      d_q        <= '0;
      data_q     <= '0;
      ord_q      <= '0;
      done_q     <= 1'b0;
`ifdef LDPC_SCHED_PREFETCH_EN
      shd_data_q <= '0;
      shd_ord_q  <= '0;
`endif
    end else if (fs_en) begin
      state_q    <= state_nx;
      w_q        <= w_nx;
      nw_q       <= nw_nx;
      b_q        <= b_nx;
      d_q        <= d_nx;
      data_q     <= data_nx;
      ord_q      <= ord_nx;
      done_q     <= done_nx;
`ifdef LDPC_SCHED_PREFETCH_EN
      shd_data_q <= shd_data_nx;
      shd_ord_q  <= shd_ord_nx;
`endif
    end
  end

endmodule

// File: tb/tb_ldpc_encoder_sched.sv
// tb/tb_ldpc_encoder_sched.sv - self-checking bench for ldpc_encoder_sched (table vectors plus random frames)
module tb_ldpc_encoder_sched;

  localparam int AW      = 8;
  localparam int ACC_LAT = 2;
`ifdef LDPC_SCHED_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fs_en = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] num_words = '0;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [359:0]  ram_rdata = '0;
  logic [2:0]    ram_order = '0;
  logic          switch_vld;
  logic [359:0]  ram_data;
  logic [5:0]    switch_array;
  logic [2:0]    order_array;
  logic          reg_clr_vld;
  logic          busy;
  logic          frame_done;

  ldpc_encoder_sched #(.AW(AW), .ACC_LAT(ACC_LAT)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .fs_en(fs_en), .frame_start(frame_start),
    .num_words(num_words), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .ram_order(ram_order), .switch_vld(switch_vld),
    .ram_data(ram_data), .switch_array(switch_array), .order_array(order_array),
    .reg_clr_vld(reg_clr_vld), .busy(busy), .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic          clr;
    logic          rd;
    logic          vld;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr;
    logic [5:0]    sw;
    logic [2:0]    ord;
    logic [359:0]  data;
  } exp_t;

  typedef struct {
    int nw;
    int mode;
    int spur;
    int ord0;
    int done_off;
    int beats;
  } vec_t;

  exp_t         exp_q[$];
  logic [359:0] mem  [256];
  logic [2:0]   omem [256];
  int           vectors = 0;
  int           miscompares = 0;

  function automatic logic [359:0] rand360();
    logic [359:0] r;
    for (int i = 0; i < 12; i++) r[i*30 +: 30] = 30'($urandom);
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic chk_zero(input string name);
    logic [383:0] all;
    all = {ram_rd_en, ram_addr, switch_vld, ram_data, switch_array, order_array,
           reg_clr_vld, busy, frame_done};
    vectors++;
    if (all != '0) begin
      miscompares++;
      $display("FAIL %s: outputs not all zero (rd=%b addr=%0d vld=%b sw=%0d ord=%0d clr=%b busy=%b done=%b data_nz=%b)",
               name, ram_rd_en, ram_addr, switch_vld, switch_array, order_array,
               reg_clr_vld, busy, frame_done, |ram_data);
    end
  endtask

  task automatic check_cycle(input exp_t e, input int idx);
    logic ok;
    ok = (reg_clr_vld == e.clr) && (ram_rd_en == e.rd) && (switch_vld == e.vld) &&
         (busy == e.busy) && (frame_done == e.done);
    if (e.rd && ram_addr != e.addr) ok = 1'b0;
    if (e.vld && (switch_array != e.sw || order_array != e.ord || ram_data != e.data)) ok = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL cycle %0d: got clr=%b rd=%b addr=%0d vld=%b sw=%0d ord=%0d busy=%b done=%b data_ok=%b; want clr=%b rd=%b addr=%0d vld=%b sw=%0d ord=%0d busy=%b done=%b",
               idx, reg_clr_vld, ram_rd_en, ram_addr, switch_vld, switch_array, order_array,
               busy, frame_done, (ram_data == e.data),
               e.clr, e.rd, e.addr, e.vld, e.sw, e.ord, e.busy, e.done);
    end
  endtask

  // Expected outputs per enabled cycle, starting with the cycle that carries frame_start.
  task automatic build_exp(input int nw);
    exp_t e;
    exp_q.delete();
    e = '0; exp_q.push_back(e);
    if (nw != 0) begin
      e = '0; e.busy = 1; e.clr = 1; exp_q.push_back(e);
      e = '0; e.busy = 1; e.rd = 1; e.addr = '0; exp_q.push_back(e);
      e = '0; e.busy = 1; exp_q.push_back(e);
      for (int w = 0; w < nw; w++) begin
        for (int b = 0; b < 45; b++) begin
          e = '0; e.busy = 1; e.vld = 1; e.sw = 6'(b); e.ord = omem[w]; e.data = mem[w];
          if (PF == 1 && b == 42 && w < nw - 1) begin
            e.rd = 1; e.addr = AW'(w + 1);
          end
          exp_q.push_back(e);
        end
        if (PF == 0 && w < nw - 1) begin
          e = '0; e.busy = 1; e.rd = 1; e.addr = AW'(w + 1); exp_q.push_back(e);
          e = '0; e.busy = 1; exp_q.push_back(e);
        end
      end
    end
    for (int i = 0; i < ACC_LAT; i++) begin
      e = '0; e.busy = 1; exp_q.push_back(e);
    end
    e = '0; e.done = 1; exp_q.push_back(e);
    e = '0; exp_q.push_back(e);
    exp_q.push_back(e);
  endtask

  // mode: 0 fs_en always 1, 1 toggling, 2 random. abort_at >= 0 stops after that many enabled cycles.
  task automatic run_frame(input int nw, input int mode, input int spur, input int ord0,
                           input int abort_at, output int done_off, output int nbeats,
                           output int ndone);
    int idx, guard;
    logic pend, live;
    logic [AW-1:0] pa;
    for (int i = 0; i < nw; i++) begin
      mem[i]  = rand360();
      omem[i] = 3'($urandom);
    end
    if (ord0 >= 0 && nw > 0) omem[0] = 3'(ord0);
    build_exp(nw);
    idx = 0; guard = 0; pend = 0; live = 0; pa = '0;
    done_off = -1; nbeats = 0; ndone = 0;
    while (idx < exp_q.size() && (abort_at < 0 || idx < abort_at) && guard < 40000) begin
      @(negedge sys_clk);
      guard++;
      case (mode)
        0:       fs_en = 1'b1;
        1:       fs_en = ~fs_en;
        default: fs_en = ($urandom_range(0, 3) != 0);
      endcase
      if (idx == 0) begin
        frame_start = 1'b1;
        num_words   = AW'(nw);
      end else begin
        frame_start = (spur != 0) && exp_q[idx].busy &&
                      (!exp_q[idx].vld || $urandom_range(0, 7) == 0);
        num_words   = AW'($urandom);
      end
      if (pend) begin
        ram_rdata = mem[pa]; ram_order = omem[pa]; pend = 0; live = 1;
      end else if (!live) begin
        ram_rdata = rand360(); ram_order = 3'($urandom);
      end
      check_cycle(exp_q[idx], idx);
      if (fs_en) begin
        live = 0;
        if (ram_rd_en) begin
          pend = 1; pa = ram_addr;
        end
        if (frame_done) begin
          ndone++; done_off = idx;
        end
        if (switch_vld) nbeats++;
        idx++;
      end
    end
    if (abort_at < 0) chk("frame_timeout", int'(idx >= exp_q.size()), 1);
    frame_start = 1'b0;
  endtask

  vec_t tbl[6];
  int   d_off, nb, nd, cnt;

  initial begin
    tbl[0] = '{1,   0, 0, 5,  51,                       45};
    tbl[1] = '{2,   0, 0, -1, (PF == 1) ? 96 : 98,      90};
    tbl[2] = '{1,   1, 0, -1, 51,                       45};
    tbl[3] = '{0,   0, 0, -1, 3,                        0};
    tbl[4] = '{3,   0, 1, -1, (PF == 1) ? 141 : 145,    135};
    tbl[5] = '{255, 0, 0, -1, (PF == 1) ? 11481 : 11989, 11475};

    #1 chk_zero("reset_async");
    repeat (3) @(negedge sys_clk);
    chk_zero("reset_held");
    rst_n = 1'b1;
    fs_en = 1'b1;
    @(negedge sys_clk);
    chk_zero("after_release");

    // Abandon a 3-word frame mid-BEAT, then confirm a clean restart.
    run_frame(3, 0, 0, -1, 30, d_off, nb, nd);
    @(negedge sys_clk);
    chk("in_beat_before_reset", int'(switch_vld), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_mid_beat");
    @(negedge sys_clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      fs_en = 1'b1;
      if (busy || frame_done || switch_vld) cnt++;
    end
    chk("idle_after_reset", cnt, 0);

    for (int t = 0; t < 6; t++) begin
      run_frame(tbl[t].nw, tbl[t].mode, tbl[t].spur, tbl[t].ord0, -1, d_off, nb, nd);
      chk($sformatf("done_offset_%0d", t), d_off, tbl[t].done_off);
      chk($sformatf("beats_%0d", t), nb, tbl[t].beats);
      chk($sformatf("done_count_%0d", t), nd, 1);
    end

    for (int r = 0; r < 10; r++) begin
      int nw;
      nw = $urandom_range(0, 5);
      run_frame(nw, $urandom_range(0, 2), $urandom_range(0, 1), -1, -1, d_off, nb, nd);
      chk($sformatf("rand_beats_%0d", r), nb, 45 * nw);
      chk($sformatf("rand_done_count_%0d", r), nd, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ldpc_encoder_sched.md
# ldpc_encoder_sched

Frame sequencer for the single-unit DVB-S2 LDPC encoder datapath. On each frame request it clears the parity accumulator, then walks the frame's 360-bit information words out of an external RAM. Each word is presented for 45 beats with the byte-select and bit-order controls the switch/order stage expects. It reports busy/done to the frame-level control above it.

## Interface
Parameters:
- AW, 8: info RAM address width; max words per frame = 2^AW-1.
- ACC_LAT, 2: drain cycles after the last beat before frame_done (covers switch/order + accumulator pipeline).

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fs_en  in  1  clock enable; all state and outputs advance only on edges with fs_en=1, otherwise hold.
- frame_start  in  1  frame request pulse; sampled in IDLE only.
- num_words  in  AW  words in this frame; latched with frame_start.
- ram_rd_en  out  1  info RAM read strobe.
- ram_addr  out  AW  info RAM word address, 0..num_words-1.
- ram_rdata  in  360  info word; valid exactly one enabled cycle after ram_rd_en.
- ram_order  in  3  bit-order code for that word; same timing as ram_rdata.
- switch_vld  out  1  beat valid to the encoder datapath.
- ram_data  out  360  registered current info word.
- switch_array  out  6  byte select, 0..44.
- order_array  out  3  bit order, 0..7.
- reg_clr_vld  out  1  one-cycle accumulator clear.
- busy  out  1  high from the cycle after an accepted frame_start until frame_done.
- frame_done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CLR, RD, LAT, BEAT, DRAIN.
- IDLE: frame_start=1 latches num_words and goes to CLR. If num_words=0, the block goes straight to DRAIN instead: no clear, no beats.
- CLR: reg_clr_vld=1 for one cycle, word counter w=0, then RD.
- RD: ram_rd_en=1, ram_addr=w, then LAT.
- LAT: capture ram_rdata into ram_data and ram_order into the order register, beat counter b=0, then BEAT.
- BEAT: switch_vld=1, switch_array=b, order_array=latched order, ram_data held. b increments 0..44.
- At b=44, if w=num_words-1: go to DRAIN. Otherwise w+1 and go to RD (or continue BEAT, see Configuration).
- DRAIN: count ACC_LAT cycles, then pulse frame_done with busy dropping in the same cycle, and return to IDLE.
- frame_start outside IDLE is ignored; no queueing.
- Counters: b is 6 bits and wraps 44→0, never reaching 45. w is AW bits and does not wrap because num_words ≤ 2^AW-1.
- Reset, asynchronous at any point mid-frame: state=IDLE. All outputs 0, including ram_data=0, switch_array=0, order_array=0. Partial frame abandoned, no frame_done.

## Timing
- All counts below are in fs_en=1 cycles; fs_en=0 cycles stretch every state by one cycle with outputs frozen.
- frame_start accepted at edge T. reg_clr_vld and busy are high in cycle T+1, ram_rd_en in T+2, and the first switch_vld in T+4.
- Without prefetch: 47 cycles per word (RD, LAT, 45 beats), giving a 2-cycle switch_vld gap between words.
- Last beat at cycle L: frame_done is high in cycle L+ACC_LAT+1.
- reg_clr_vld always precedes the first switch_vld by exactly 3 cycles.

## Configuration
- LDPC_SCHED_PREFETCH_EN defined:
  - During BEAT b=42 of word w (not the last word), issue ram_rd_en with ram_addr=w+1.
  - At b=43, capture the returned word and order into shadow registers.
  - At b=44, go directly to BEAT b=0 of word w+1, loading ram_data/order_array from the shadow registers.
  - Result: switch_vld is continuous across words, at 45 cycles per word after the first.
  - Frame length = 3 + 45·num_words + ACC_LAT + 1 cycles from acceptance to frame_done.
- Undefined: no shadow registers, 47 cycles per word as above.

## Test plan
- Reset mid-BEAT, fs_en=1, num_words=3: outputs all 0 immediately, busy=0, no frame_done; a new frame_start is then accepted normally.
- num_words=1, ram_order=5, fs_en=1: reg_clr_vld at T+1; 45 switch_vld with switch_array 0..44 and order_array=5; frame_done at T+4+44+ACC_LAT+1 = T+51.
- num_words=2, no prefetch: ram_addr 0 then 1, with a 2-cycle switch_vld gap between words; total 94 beats-plus-gap cycles. With LDPC_SCHED_PREFETCH_EN: ram_rd_en at word-0 beat 42, 90 contiguous switch_vld.
- fs_en toggling 1/0 every cycle, num_words=1: same output sequence as the fs_en=1 case with each value held two cycles; frame_done still a single enabled cycle.
- num_words=0: no reg_clr_vld, no ram_rd_en, no switch_vld; frame_done ACC_LAT+1 cycles after acceptance.
- frame_start pulsed during BEAT and during DRAIN: ignored; exactly one frame_done, and busy low one cycle before the next accepted request.
